mult_8x8_sequencer: RTL and testbench
=====================================

Name: mult_8x8_sequencer

Overview:
Sequential controller for the 8x8 signed shift-add multiplier. It owns the X/A/B product registers and the latched multiplicand S, and it drives the existing adder_9_bit (add/sub select) through 8 add/shift steps. It sits between the debounced board inputs (switches, Run, ClearA_LoadB) and the hex-display and LED outputs. The final step subtracts, giving a correct two's-complement product in {X, A, B}.

Parameters:
CLEAR_ON_RUN, 1, when 1 the START state zeroes X and A before step 0; when 0, A/X keep their contents (accumulate mode, lab-demo only)

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous, active-low reset
Run  input  1  start request, level; already synchronized and debounced
ClearA_LoadB  input  1  clear X/A and load B from SW; synchronized and debounced
SW  input  8  operand switches: B on load, S on start
Aval  output  8  A register (product high byte)
Bval  output  8  B register (product low byte)
Xval  output  1  X sign-extension bit
Busy  output  1  high in START/ADD/SHIFT
Done  output  1  high in DONE

Behaviour:
- Reset (async, Reset_n=0): state=IDLE, A=B=S=0, X=0, count=0, Busy=0, Done=0. Reset mid-multiply aborts immediately. No partial result is kept.
- States: IDLE, START, ADD, SHIFT, DONE. The state machine is a 3-bit enum with a 3-bit step counter (count).
- IDLE:
  - ClearA_LoadB=1: X<=0, A<=0, B<=SW. Stay in IDLE.
  - else Run=1: go to START. ClearA_LoadB has priority if both are high.
- START (1 cycle): S<=SW; count<=0. If CLEAR_ON_RUN, X<=0 and A<=0. Next state is ADD.
- ADD (1 cycle):
  - If B[0]=1: {X,A} <= adder output S9[8:0], with sub=(count==7).
  - If B[0]=0: no register change, but the cycle is still consumed. Latency is fixed.
  - Adder hookup: A-in=A, B-in=S, sub as above.
  - Next state is SHIFT.
- SHIFT (1 cycle): arithmetic right shift of {X,A,B}. X unchanged, A<={X,A[7:1]}, B<={A[0],B[7:1]}.
  - If count==7, next state is DONE. Else count<=count+1 and next state is ADD.
- DONE: Done=1, registers hold. Stay while Run=1. Go to IDLE when Run=0, which prevents retrigger on a held button.
- Latency: Run sampled high in IDLE, then START + 8x(ADD+SHIFT) = 17 cycles, then DONE on the 18th edge.
- Ignored while Busy: Run and ClearA_LoadB. SW changes after START have no effect, because S is latched.
- In DONE, ClearA_LoadB is ignored. It must be applied after returning to IDLE.
- Product = signed 16-bit {A,B}. X equals the product sign, except in accumulate mode.
- Arithmetic: the adder sign-extends both operands to 9 bits. The sub path inverts S and uses cin=1. Overflow cannot occur for an 8x8 product; no saturation.
- Outputs are registered values of A/B/X. Busy and Done are decoded combinationally from state.

Decomposition:
- Shared package mult_pkg:
  - typedef enum logic [2:0] mult_state_t {IDLE, START, ADD, SHIFT, DONE}
  - localparam WIDTH=8
  - localparam N_STEPS=8
  - localparam LAST_STEP=N_STEPS-1
- Sub-module: instantiate the existing adder_9_bit as-is; no new sub-module.
- Register file and state machine are kept in one module, with always_ff for state and registers and always_comb for next-state logic.

Test Plan:
- Reset_n low during step 4 -> next sample shows IDLE, A=B=0, X=0, Busy=0, Done=0. A new load and run of 0x02 x 0x03 then gives A=0x00, B=0x06, X=0.
- Load B=0x03, run with SW=0x02 -> Done after exactly 18 edges from Run, A=0x00, B=0x06, X=0.
- Load B=0x07, run with SW=0xFD (-3) -> A=0xFF, B=0xEB (-21), X=1.
- Load B=0xFF (-1), run with SW=0x03 -> step 7 uses sub=1; A=0xFF, B=0xFD, X=1.
- Load B=0x80, run with SW=0x80 -> A=0x40, B=0x00, X=0 (+16384).
- Run held high through DONE -> stays in DONE with no second run. Toggling SW and ClearA_LoadB while Busy changes nothing.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the 8x8 signed shift-add multiplier.
//   mult_state_t : sequencer states
//   WIDTH        : operand width
//   N_STEPS      : number of add/shift steps
//   LAST_STEP    : index of the final (subtracting) step
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } mult_state_t;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned N_STEPS   = 8;
    localparam int unsigned LAST_STEP = N_STEPS - 1;

endpackage

// File: rtl/adder_9_bit.sv
// 9-bit add/subtract unit used by the multiplier datapath.
//   A  : 8-bit operand, sign-extended to 9 bits
//   B  : 8-bit operand, sign-extended to 9 bits
//   fn : 0 = A + B, 1 = A - B
//   S  : 9-bit result {sign, value}
module adder_9_bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       fn,
    output logic [8:0] S
);

    logic [8:0] a9;
    logic [8:0] b9;

    // Subtraction is A + ~B + 1.
    always_comb begin
        a9 = {A[7], A};
        b9 = fn ? ~{B[7], B} : {B[7], B};
        S  = a9 + b9 + {8'b0, fn};
    end

endmodule

// File: rtl/mult_8x8_sequencer.sv
// Sequencer and register file for the 8x8 signed shift-add multiplier.
// Product appears in {A, B}; X carries the sign extension.
//   Clk          : system clock
//   Reset_n      : asynchronous active-low reset
//   Run          : start request (level)
//   ClearA_LoadB : clear X/A and load B from SW (IDLE only)
//   SW           : operand switches (B on load, S on start)
//   Aval/Bval    : A and B registers
//   Xval         : X sign-extension bit
//   Busy         : high in START/ADD/SHIFT
//   Done         : high in DONE
module mult_8x8_sequencer
    import mult_pkg::*;
#(
    parameter bit CLEAR_ON_RUN = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done
);

    mult_state_t      state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             x_q, x_d;

    logic             last_step;
    logic [WIDTH:0]   sum;

    assign last_step = (count_q == 3'(LAST_STEP));

    // The final step subtracts: the multiplier's MSB has negative weight.
    adder_9_bit u_adder (
        .A  (a_q),
        .B  (s_q),
        .fn (last_step),
        .S  (sum)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            x_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        x_d     = x_q;

        unique case (state_q)
            IDLE: begin
                if (ClearA_LoadB) begin
                    x_d = 1'b0;
                    a_d = '0;
                    b_d = SW;
                end else if (Run) begin
                    state_d = START;
                end
            end
            START: begin
                s_d     = SW;
                count_d = '0;
                if (CLEAR_ON_RUN) begin
                    x_d = 1'b0;
                    a_d = '0;
                end
                state_d = ADD;
            end
            ADD: begin
                // Cycle is spent even when B[0]=0 to keep latency fixed.
                if (b_q[0]) begin
                    {x_d, a_d} = sum;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (last_step) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + 3'd1;
                    state_d = ADD;
                end
            end
            DONE: begin
                // Wait for Run release so a held button cannot retrigger.
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Aval = a_q;
        Bval = b_q;
        Xval = x_q;
        Busy = (state_q == START) || (state_q == ADD) || (state_q == SHIFT);
        Done = (state_q == DONE);
    end

endmodule

// File: tb/tb_mult_8x8_sequencer.sv
// Scoreboard bench for mult_8x8_sequencer: expected products from a plain
// signed multiply, checked by a monitor on each rising Done.
module tb_mult_8x8_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Run = 1'b0;
    logic       ClearA_LoadB = 1'b0;
    logic [7:0] SW = '0;
    logic [7:0] Aval, Bval;
    logic       Xval, Busy, Done;

    mult_8x8_sequencer #(.CLEAR_ON_RUN(1'b1)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .SW           (SW),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Busy         (Busy),
        .Done         (Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [16:0] res;    // {X, A, B}
        int          start;  // cycle count when Run was raised
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic [7:0] model_b = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compare on each rising edge of Done.
    logic prev_done = 1'b0;
    always @(negedge Clk) begin
        if (Done && !prev_done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got Done=1, expected no pending product");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("product", {Xval, Aval, Bval}, e.res);
                chk("latency", 17'(cyc - e.start), 17'd18);
            end
        end
        prev_done = Done;
    end

    task automatic load_b(input logic [7:0] b);
        @(negedge Clk);
        ClearA_LoadB = 1'b1;
        SW = b;
        @(negedge Clk);
        ClearA_LoadB = 1'b0;
        SW = 8'($urandom);
        model_b = b;
        chk("load", {Xval, Aval, Bval}, {9'd0, b});
    endtask

    function automatic logic [16:0] expect_of(input logic [7:0] b, input logic [7:0] s);
        logic signed [15:0] p;
        p = $signed(b) * $signed(s);
        return {p[15], p};
    endfunction

    task automatic multiply(input logic [7:0] s, input bit held, input bit noisy);
        exp_t e;
        bit   got;
        @(negedge Clk);
        Run = 1'b1;
        SW = s;
        e.res = expect_of(model_b, s);
        e.start = cyc;
        exp_q.push_back(e);
        @(negedge Clk);
        @(negedge Clk);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done) begin
                got = 1'b1;
                break;
            end
            if (noisy) begin
                SW = 8'($urandom);
                ClearA_LoadB = 1'($urandom);
                Run = held ? 1'b1 : 1'($urandom);
            end
            @(negedge Clk);
        end
        ClearA_LoadB = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no Done within 40 cycles, expected Done");
            void'(exp_q.pop_back());
            Run = 1'b0;
            return;
        end
        if (held) begin
            Run = 1'b1;
            for (int i = 0; i < 4; i++) begin
                SW = 8'($urandom);
                ClearA_LoadB = 1'b1;
                @(negedge Clk);
                chk("held_done", {15'd0, Busy, Done}, 17'd1);
                chk("held_regs", {Xval, Aval, Bval}, e.res);
            end
            ClearA_LoadB = 1'b0;
        end
        Run = 1'b0;
        @(negedge Clk);
        chk("back_idle", {15'd0, Busy, Done}, 17'd0);
        chk("idle_regs", {Xval, Aval, Bval}, e.res);
        model_b = e.res[7:0];
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        chk("reset_state", {13'd0, Xval, Busy, Done, |Aval | |Bval}, 17'd0);
        Reset_n = 1'b1;

        // Abort in the middle of the multiply (step 4).
        load_b(8'h55);
        @(negedge Clk);
        Run = 1'b1;
        SW = 8'h33;
        repeat (10) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("abort_reset", {Xval, Aval, Bval}, 17'd0);
        chk("abort_flags", {15'd0, Busy, Done}, 17'd0);
        void'(exp_q.pop_back());
        Run = 1'b0;
        model_b = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        load_b(8'h02);
        multiply(8'h03, 1'b0, 1'b0);

        // Directed boundary cases.
        load_b(8'h03); multiply(8'h02, 1'b0, 1'b0);
        load_b(8'h07); multiply(8'hFD, 1'b0, 1'b1);
        load_b(8'hFF); multiply(8'h03, 1'b1, 1'b1);
        load_b(8'h80); multiply(8'h80, 1'b0, 1'b0);
        load_b(8'h7F); multiply(8'h80, 1'b1, 1'b0);

        // Random operands; sometimes reuse B from the previous product
        // with a non-zero A left over.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) != 0) load_b(8'($urandom));
            multiply(8'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge Clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pending: got %0d unchecked products, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
